clk_en_gen: RTL and testbench
=============================

Name: clk_en_gen

Overview:
- Parametrised multi-channel fractional clock-enable generator running on the 108 MHz system clock.
- Replaces the fixed integer counters in the board top (DAC enable /5, UMA /30) with a single block.
- Each channel has a runtime-loadable INC/MOD ratio, giving an average enable rate of CLK·INC/MOD.
- Each channel also provides a square-wave phase output. All channels can be phase-aligned with one strobe.

Parameters:
COUNT, 4, number of independent enable channels (1..16)
ACC_WIDTH, 16, width of INC, MOD and each accumulator
DEFAULT_INC, 1, INC value loaded into every channel at reset
DEFAULT_MOD, 30, MOD value loaded into every channel at reset

Ports:
CLK  in  1  system clock (108 MHz)
RESET_n  in  1  asynchronous active-low reset
ENABLE  in  COUNT  per-channel run enable; when low, the accumulator holds and no pulses are produced
LOAD  in  COUNT  per-channel one-cycle strobe; captures the channel's INC/MOD slice
INC  in  COUNT*ACC_WIDTH  increment per channel; channel i uses bits [i*ACC_WIDTH +: ACC_WIDTH]
MOD  in  COUNT*ACC_WIDTH  modulus per channel, same slicing as INC
SYNC  in  1  one-cycle strobe; clears all accumulators and phase outputs together
CLK_EN  out  COUNT  per-channel one-cycle enable pulse, registered
PHASE  out  COUNT  per-channel square wave; toggles on every CLK_EN pulse
BAD_CFG  out  COUNT  high while the channel's active config is invalid

Behaviour:
- Clock and reset: one clock, CLK. RESET_n is asynchronous and active-low.
- Reset state, per channel:
  - acc = 0
  - inc_r = DEFAULT_INC, mod_r = DEFAULT_MOD
  - CLK_EN = 0, PHASE = 0
  - BAD_CFG = (DEFAULT_INC==0 || DEFAULT_INC>=DEFAULT_MOD)
- Per-channel step, on each CLK edge with ENABLE[i]=1 and no LOAD/SYNC:
  - sum = acc + inc_r, computed at ACC_WIDTH+1 bits so it never overflows.
  - If sum >= mod_r: acc <= sum - mod_r, CLK_EN[i] <= 1, PHASE[i] toggles.
  - Otherwise: acc <= sum[ACC_WIDTH-1:0], CLK_EN[i] <= 0.
- CLK_EN latency: the pulse is high for exactly the one cycle after the wrap edge.
  - With INC=1, MOD=N, the first pulse occurs on the Nth edge after reset release, then every N cycles.
- Average rate is exactly INC/MOD pulses per clock with no drift. Consecutive pulse spacing is floor or ceil of MOD/INC.
- ENABLE[i]=0: acc, inc_r, mod_r and PHASE hold; CLK_EN[i] <= 0.
- Invalid config: a channel is invalid when inc_r==0, mod_r==0, or inc_r>=mod_r.
  - BAD_CFG[i]=1 (combinational from inc_r/mod_r).
  - Channel produces no pulses; acc <= 0; PHASE holds.
  - No saturation mode.
- LOAD[i]:
  - inc_r <= INC slice, mod_r <= MOD slice, acc <= 0.
  - CLK_EN[i] <= 0 that cycle, even if the old config would have wrapped.
  - PHASE holds.
  - First pulse with the new config follows the same timing as after reset.
- SYNC:
  - All acc <= 0, all PHASE <= 0, all CLK_EN <= 0.
  - Takes priority over step and ENABLE. If LOAD[i] coincides with SYNC, the LOAD is still applied.
- Priority per channel: SYNC/LOAD clear > invalid-config clear > ENABLE-gated step.
- Reset mid-operation clears everything immediately (asynchronous). Release follows reset-state timing.
- Channels are fully independent apart from SYNC. No combinational path from any input to CLK_EN or PHASE.

Test Plan:
- Default reset, ENABLE=all 1s: CLK_EN[0] first pulse on edge 30 after RESET_n rises, then every 30 cycles; PHASE[0] toggles every 30 cycles; BAD_CFG=0.
- LOAD ch1 with INC=1, MOD=5: pulses every 5 cycles (21.6 MHz DAC rate); 1000-cycle window gives exactly 200 pulses.
- LOAD ch2 with INC=2, MOD=5: acc sequence 2,4,1(pulse),3,0(pulse), repeating; gaps alternate 3 and 2 cycles; 1000 cycles give 400 pulses.
- Drop ENABLE[1] for 7 cycles mid-count (acc=3): acc holds at 3 and no pulses; after re-enable the next pulse comes 2 cycles later.
- LOAD ch3 with INC=5, MOD=5, then INC=0, MOD=10: BAD_CFG[3]=1 both times, no CLK_EN[3] pulses; reload INC=1, MOD=2 → BAD_CFG=0 and a pulse every 2 cycles.
- Run ch0–ch3 with different ratios, assert SYNC on the cycle ch1 would wrap: that pulse is suppressed, all PHASE=0, all acc restart; assert RESET_n low mid-run → all outputs 0 asynchronously.

Source files
------------

// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel fractional clock-enable generator.
// Each channel accumulates inc_r per enabled cycle and wraps at mod_r,
// emitting a registered one-cycle CLK_EN pulse per wrap (average rate
// CLK*INC/MOD) and toggling a square-wave PHASE output on every pulse.
// SYNC restarts every channel together so their phases line up.
module clk_en_gen #(
  parameter int COUNT       = 4,
  parameter int ACC_WIDTH   = 16,
  parameter int DEFAULT_INC = 1,
  parameter int DEFAULT_MOD = 30
) (
  input  logic                       CLK,
  input  logic                       RESET_n,
  input  logic [COUNT-1:0]           ENABLE,
  input  logic [COUNT-1:0]           LOAD,
  input  logic [COUNT*ACC_WIDTH-1:0] INC,
  input  logic [COUNT*ACC_WIDTH-1:0] MOD,
  input  logic                       SYNC,
  output logic [COUNT-1:0]           CLK_EN,
  output logic [COUNT-1:0]           PHASE,
  output logic [COUNT-1:0]           BAD_CFG
);

  localparam logic [ACC_WIDTH-1:0] RST_INC = ACC_WIDTH'(DEFAULT_INC);
  localparam logic [ACC_WIDTH-1:0] RST_MOD = ACC_WIDTH'(DEFAULT_MOD);

  for (genvar g = 0; g < COUNT; g++) begin : g_ch
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] inc_r;
    logic [ACC_WIDTH-1:0] mod_r;
    logic [ACC_WIDTH-1:0] acc_nxt;
    logic [ACC_WIDTH:0]   sum;
    logic                 wrap;
    logic                 bad;
    logic                 en_q;
    logic                 ph_q;

    // Next accumulator value; sum carries one extra bit so acc+inc never overflows.
    always_comb begin
      sum     = {1'b0, acc} + {1'b0, inc_r};
      wrap    = (sum >= {1'b0, mod_r});
      acc_nxt = sum[ACC_WIDTH-1:0];
      if (wrap) begin
        acc_nxt = ACC_WIDTH'(sum - {1'b0, mod_r});
      end
    end

    // A zero ratio, zero modulus or ratio >= 1 cannot produce a meaningful enable.
    always_comb begin
      bad = (inc_r == '0) || (mod_r == '0) || (inc_r >= mod_r);
    end

    // Channel state: strobes clear first, then bad config, then the gated step.
    always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
        acc   <= '0;
        inc_r <= RST_INC;
        mod_r <= RST_MOD;
        en_q  <= 1'b0;
        ph_q  <= 1'b0;
      end else if (SYNC || LOAD[g]) begin
        // A coincident LOAD still takes effect when SYNC is asserted.
        acc  <= '0;
        en_q <= 1'b0;
        if (LOAD[g]) begin
          inc_r <= INC[g*ACC_WIDTH +: ACC_WIDTH];
          mod_r <= MOD[g*ACC_WIDTH +: ACC_WIDTH];
        end
        if (SYNC) begin
          ph_q <= 1'b0;
        end
      end else if (bad) begin
        acc  <= '0;
        en_q <= 1'b0;
      end else if (ENABLE[g]) begin
        acc  <= acc_nxt;
        en_q <= wrap;
        if (wrap) begin
          ph_q <= ~ph_q;
        end
      end else begin
        en_q <= 1'b0;
      end
    end

    assign CLK_EN[g]  = en_q;
    assign PHASE[g]   = ph_q;
    assign BAD_CFG[g] = bad;
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen with four 16-bit channels at default 1/30.
module tb_clk_en_gen;

  logic        CLK;
  logic        RESET_n;
  logic [3:0]  ENABLE;
  logic [3:0]  LOAD;
  logic [63:0] INC;
  logic [63:0] MOD;
  logic        SYNC;
  logic [3:0]  CLK_EN;
  logic [3:0]  PHASE;
  logic [3:0]  BAD_CFG;

  int total;
  int bad;

  clk_en_gen #(
    .COUNT(4), .ACC_WIDTH(16), .DEFAULT_INC(1), .DEFAULT_MOD(30)
  ) dut (
    .CLK(CLK), .RESET_n(RESET_n), .ENABLE(ENABLE), .LOAD(LOAD),
    .INC(INC), .MOD(MOD), .SYNC(SYNC),
    .CLK_EN(CLK_EN), .PHASE(PHASE), .BAD_CFG(BAD_CFG)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance one clock; sample point is 1 ns after the rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_cfg(input int ch, input int i, input int m);
    INC[ch*16 +: 16] = 16'(i);
    MOD[ch*16 +: 16] = 16'(m);
  endtask

  initial begin
    int errs;
    int cnt1, cnt2, cnt3;
    int first0, first1, first2, first3;
    logic [3:0] exp_en;
    logic [3:0] ph_30, ph_60;
    logic       ph_hold;

    total   = 0;
    bad     = 0;
    RESET_n = 1'b0;
    ENABLE  = 4'hF;
    LOAD    = 4'h0;
    SYNC    = 1'b0;
    INC     = '0;
    MOD     = '0;

    // ---- reset state ----
    step(); step(); step();
    chk("rst_clk_en", 32'(CLK_EN), 32'h0);
    chk("rst_phase", 32'(PHASE), 32'h0);
    chk("rst_bad_cfg", 32'(BAD_CFG), 32'h0);

    // ---- default 1/30 on all channels ----
    RESET_n = 1'b1;
    errs = 0;
    ph_30 = '0;
    ph_60 = '0;
    for (int k = 1; k <= 90; k++) begin
      step();
      exp_en = (k % 30 == 0) ? 4'hF : 4'h0;
      if (CLK_EN !== exp_en) errs++;
      if (k == 30) ph_30 = PHASE;
      if (k == 60) ph_60 = PHASE;
    end
    chk("def_pulse_pattern", 32'(errs), 0);
    chk("def_phase_30", 32'(ph_30), 32'hF);
    chk("def_phase_60", 32'(ph_60), 32'h0);
    chk("def_phase_90", 32'(PHASE), 32'hF);

    // ---- ch1 1/5 and ch2 2/5 ----
    set_cfg(1, 1, 5);
    set_cfg(2, 2, 5);
    LOAD = 4'b0110;
    step();
    LOAD = 4'h0;
    chk("load_no_pulse", 32'(CLK_EN[2:1]), 0);
    cnt1 = 0; cnt2 = 0; first1 = 0; errs = 0;
    for (int k = 1; k <= 1000; k++) begin
      step();
      if (CLK_EN[1]) cnt1++;
      if (CLK_EN[2]) cnt2++;
      if (first1 == 0 && CLK_EN[1]) first1 = k;
      if (CLK_EN[1] !== (k % 5 == 0)) errs++;
      if (CLK_EN[2] !== ((k % 5 == 3) || (k % 5 == 0))) errs++;
    end
    chk("ch1_first", 32'(first1), 5);
    chk("ch1_count", 32'(cnt1), 200);
    chk("ch2_count", 32'(cnt2), 400);
    chk("ch12_pattern", 32'(errs), 0);

    // ---- ENABLE[1] drop with acc=3 ----
    step(); step(); step();
    ph_hold = PHASE[1];
    ENABLE = 4'b1101;
    cnt1 = 0;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (CLK_EN[1]) cnt1++;
    end
    chk("dis_no_pulse", 32'(cnt1), 0);
    chk("dis_phase_hold", 32'(PHASE[1]), 32'(ph_hold));
    ENABLE = 4'hF;
    step();
    chk("reen_edge1", 32'(CLK_EN[1]), 0);
    step();
    chk("reen_edge2", 32'(CLK_EN[1]), 1);

    // ---- invalid configs on ch3 ----
    set_cfg(3, 5, 5);
    LOAD = 4'b1000;
    step();
    LOAD = 4'h0;
    chk("bad_inc_eq_mod", 32'(BAD_CFG), 32'h8);
    cnt3 = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (CLK_EN[3]) cnt3++;
    end
    chk("bad_no_pulse_a", 32'(cnt3), 0);
    set_cfg(3, 0, 10);
    LOAD = 4'b1000;
    step();
    LOAD = 4'h0;
    chk("bad_inc_zero", 32'(BAD_CFG), 32'h8);
    cnt3 = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (CLK_EN[3]) cnt3++;
    end
    chk("bad_no_pulse_b", 32'(cnt3), 0);
    set_cfg(3, 1, 2);
    LOAD = 4'b1000;
    step();
    LOAD = 4'h0;
    chk("good_again", 32'(BAD_CFG), 32'h0);
    cnt3 = 0; first3 = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (CLK_EN[3]) cnt3++;
      if (first3 == 0 && CLK_EN[3]) first3 = k;
    end
    chk("ch3_first", 32'(first3), 2);
    chk("ch3_count", 32'(cnt3), 10);

    // ---- SYNC on ch1's wrap cycle ----
    set_cfg(0, 1, 3);
    set_cfg(1, 1, 5);
    set_cfg(2, 2, 5);
    set_cfg(3, 1, 2);
    LOAD = 4'hF;
    step();
    LOAD = 4'h0;
    step(); step(); step(); step();
    SYNC = 1'b1;
    step();
    SYNC = 1'b0;
    chk("sync1_clk_en", 32'(CLK_EN), 0);
    chk("sync1_phase", 32'(PHASE), 0);
    first0 = 0; first1 = 0; first2 = 0; first3 = 0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (first0 == 0 && CLK_EN[0]) first0 = k;
      if (first1 == 0 && CLK_EN[1]) first1 = k;
      if (first2 == 0 && CLK_EN[2]) first2 = k;
      if (first3 == 0 && CLK_EN[3]) first3 = k;
    end
    chk("sync_first_ch0", 32'(first0), 3);
    chk("sync_first_ch1", 32'(first1), 5);
    chk("sync_first_ch2", 32'(first2), 3);
    chk("sync_first_ch3", 32'(first3), 2);
    chk("pre_sync2_phase", 32'(PHASE), 32'h7);

    // SYNC again with a coincident LOAD of ch3 to 1/4
    set_cfg(3, 1, 4);
    SYNC = 1'b1;
    LOAD = 4'b1000;
    step();
    SYNC = 1'b0;
    LOAD = 4'h0;
    chk("sync2_clk_en", 32'(CLK_EN), 0);
    chk("sync2_phase", 32'(PHASE), 0);
    first1 = 0; first3 = 0;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (first1 == 0 && CLK_EN[1]) first1 = k;
      if (first3 == 0 && CLK_EN[3]) first3 = k;
    end
    chk("sync2_first_ch1", 32'(first1), 5);
    chk("sync2_first_ch3", 32'(first3), 4);
    chk("pre_rst_phase", 32'(PHASE), 32'hB);
    chk("pre_rst_clk_en", 32'(CLK_EN), 32'h6);

    // ---- asynchronous reset mid-run ----
    #2;
    RESET_n = 1'b0;
    #1;
    chk("async_rst_clk_en", 32'(CLK_EN), 0);
    chk("async_rst_phase", 32'(PHASE), 0);
    chk("async_rst_bad", 32'(BAD_CFG), 0);
    step();
    RESET_n = 1'b1;
    errs = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      exp_en = (k == 30) ? 4'hF : 4'h0;
      if (CLK_EN !== exp_en) errs++;
    end
    chk("post_rst_pattern", 32'(errs), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
